// File: rtl/ip_forward_rewrite.sv
// rtl/ip_forward_rewrite.sv - IPv4 next-hop header rewrite / CPU redirect stage
module ip_forward_rewrite #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int META_DEPTH_BITS      = 2
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  input  logic                                lu_valid,
  output logic                                lu_ready,
  input  logic                                lu_hit,
  input  logic [47:0]                         lu_dest_mac,
  input  logic [7:0]                          lu_oq,
  input  logic [47:0]                         port_mac0,
  input  logic [47:0]                         port_mac1,
  input  logic [47:0]                         port_mac2,
  input  logic [47:0]                         port_mac3,
  output logic [31:0]                         fwd_count,
  output logic [31:0]                         miss_count,
  output logic [31:0]                         ttl_exp_count
);

  localparam int DEPTH = 1 << META_DEPTH_BITS;
  localparam logic [META_DEPTH_BITS:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_META, ST_BODY} state_t;

  state_t state_q, state_d;

  logic                          meta_hit_q [DEPTH];
  logic [47:0]                   meta_mac_q [DEPTH];
  logic [7:0]                    meta_oq_q  [DEPTH];
  logic [META_DEPTH_BITS:0]      wr_ptr_q, rd_ptr_q;
  logic [META_DEPTH_BITS-1:0]    rd_idx;
  logic                          fifo_empty, fifo_full, wr_en;

  logic [C_M_AXIS_DATA_WIDTH-1:0]   m_data_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_strb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_user_q;
  logic                             m_valid_q, m_last_q;
  logic [31:0]                      fwd_q, miss_q, ttl_q;

  logic                             out_free, s_ready, accept, first_acc;
  logic                             h_hit, oq_ok;
  logic [47:0]                      h_mac, sel_mac;
  logic [7:0]                       h_oq, src_oh, dst_oh, ttl;
  logic [15:0]                      etype, csum, csum_new;
  logic [16:0]                      csum_sum;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   out_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  out_user;
  logic                             inc_fwd, inc_miss, inc_ttl;

  assign rd_idx     = rd_ptr_q[META_DEPTH_BITS-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[META_DEPTH_BITS] != rd_ptr_q[META_DEPTH_BITS]) &&
                      (wr_ptr_q[META_DEPTH_BITS-1:0] == rd_idx);
  assign lu_ready   = !fifo_full;
  assign wr_en      = lu_valid && !fifo_full;

  // First beats need a lookup result at the FIFO head; body beats flow freely.
  assign out_free  = !m_valid_q || M_AXIS_TREADY;
  assign s_ready   = out_free && ((state_q == ST_BODY) || (state_q == ST_IDLE && !fifo_empty));
  assign accept    = S_AXIS_TVALID && s_ready;
  assign first_acc = accept && (state_q == ST_IDLE);

  assign h_hit = meta_hit_q[rd_idx];
  assign h_mac = meta_mac_q[rd_idx];
  assign h_oq  = meta_oq_q[rd_idx];

  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) begin
      meta_hit_q[wr_ptr_q[META_DEPTH_BITS-1:0]] <= lu_hit;
      meta_mac_q[wr_ptr_q[META_DEPTH_BITS-1:0]] <= lu_dest_mac;
      meta_oq_q[wr_ptr_q[META_DEPTH_BITS-1:0]]  <= lu_oq;
    end
  end

  always_comb begin
    src_oh   = S_AXIS_TUSER[SRC_PORT_POS +: 8];
    dst_oh   = S_AXIS_TUSER[DST_PORT_POS +: 8];
    etype    = S_AXIS_TDATA[159:144];
    ttl      = S_AXIS_TDATA[79:72];
    csum     = S_AXIS_TDATA[63:48];
    oq_ok    = h_oq inside {8'h01, 8'h04, 8'h10, 8'h40};
    case (h_oq)
      8'h04:   sel_mac = port_mac1;
      8'h10:   sel_mac = port_mac2;
      8'h40:   sel_mac = port_mac3;
      default: sel_mac = port_mac0;
    endcase
    // TTL sits in the high byte of its 16-bit checksum word, so a decrement adds 0x0100.
    csum_sum = {1'b0, csum} + 17'h00100;
    csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};
    out_data = S_AXIS_TDATA;
    out_user = S_AXIS_TUSER;
    inc_fwd  = 1'b0;
    inc_miss = 1'b0;
    inc_ttl  = 1'b0;
    if (state_q == ST_IDLE && dst_oh == 8'd0) begin
      if (etype != 16'h0800 || !h_hit || !oq_ok) begin
        out_user[DST_PORT_POS +: 8] = {src_oh[6:0], 1'b0};
        inc_miss = 1'b1;
      end else if (ttl <= 8'd1) begin
        out_user[DST_PORT_POS +: 8] = {src_oh[6:0], 1'b0};
        inc_ttl = 1'b1;
      end else begin
        out_data[255:208] = h_mac;
        out_data[207:160] = sel_mac;
        out_data[79:72]   = ttl - 8'd1;
        out_data[63:48]   = csum_new;
        out_user[DST_PORT_POS +: 8] = h_oq;
        inc_fwd = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (S_AXIS_TVALID && fifo_empty && !wr_en) state_d = ST_WAIT_META;
        else if (first_acc && !S_AXIS_TLAST)      state_d = ST_BODY;
      end
      ST_WAIT_META: if (!fifo_empty || wr_en)     state_d = ST_IDLE;
      ST_BODY:      if (accept && S_AXIS_TLAST)   state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_user_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      fwd_q     <= '0;
      miss_q    <= '0;
      ttl_q     <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (first_acc) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        fwd_q    <= fwd_q  + {31'd0, inc_fwd};
        miss_q   <= miss_q + {31'd0, inc_miss};
        ttl_q    <= ttl_q  + {31'd0, inc_ttl};
      end
      if (accept) begin
        m_data_q  <= out_data;
        m_strb_q  <= S_AXIS_TSTRB;
        m_user_q  <= out_user;
        m_last_q  <= S_AXIS_TLAST;
        m_valid_q <= 1'b1;
      end else if (M_AXIS_TREADY) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TSTRB  = m_strb_q;
  assign M_AXIS_TUSER  = m_user_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign fwd_count     = fwd_q;
  assign miss_count    = miss_q;
  assign ttl_exp_count = ttl_q;

endmodule
